// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin two-requester byte scheduler feeding a 16x-clocked UART transmitter
//   mclk16      : 16x baud clock, all logic on its rising edge
//   reset       : synchronous active-high reset
//   req0/req1   : send requests, held high until the matching ack
//   data0/data1 : request bytes, stable while the request is high
//   ack0/ack1   : one-cycle pulse when the requester's byte is captured
//   uart_write  : one-cycle write strobe to the UART
//   uart_data   : captured byte presented to the UART
//   uart_txrdy  : UART transmitter idle flag
//   busy        : high whenever the scheduler is not idle
//   grant_id    : requester being served, held while idle
//   err         : one-cycle pulse when the UART never acknowledges a write
module uart_tx_sched #(
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 32
) (
    input  logic       mclk16,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       uart_write,
    output logic [7:0] uart_data,
    input  logic       uart_txrdy,
    output logic       busy,
    output logic       grant_id,
    output logic       err
);
    localparam int CNT_MAX = GAP_CYCLES > ACK_TIMEOUT ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int CW = CNT_MAX > 0 ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] TO_LAST  = CW'(ACK_TIMEOUT > 0 ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE, S_GAP} state_t;

    state_t          r_state;
    state_t          w_next;
    state_t          w_after;
    logic            r_last;
    logic            r_grant;
    logic [7:0]      r_hold;
    logic [CW-1:0]   r_cnt;
    logic            w_cap;
    logic            w_win;
    logic            w_timeout;

    always_comb begin
        w_next    = r_state;
        w_cap     = 1'b0;
        w_timeout = 1'b0;
        // with both requesting, the one not served last wins; otherwise whoever asks
        w_win     = (req0 && req1) ? ~r_last : ~req0;
        // a zero-length gap skips the GAP state entirely
        w_after   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        case (r_state)
            S_IDLE: begin
                if ((req0 || req1) && uart_txrdy) begin
                    w_cap  = 1'b1;
                    w_next = S_LOAD;
                end
            end
            S_LOAD: w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!uart_txrdy) begin
                    w_next = S_WAIT_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = w_after;
                end
            end
            S_WAIT_DONE: w_next = uart_txrdy ? w_after : S_WAIT_DONE;
            S_GAP: w_next = (r_cnt == GAP_LAST) ? S_IDLE : S_GAP;
            default: w_next = S_IDLE;
        endcase
    end

    // pulses are gated by reset so nothing escapes during a reset cycle
    assign ack0       = w_cap & ~w_win & ~reset;
    assign ack1       = w_cap & w_win & ~reset;
    assign err        = w_timeout & ~reset;
    assign uart_write = (r_state == S_LOAD) & ~reset;
    assign uart_data  = r_hold;
    assign busy       = r_state != S_IDLE;
    assign grant_id   = r_grant;

    always_ff @(posedge mclk16) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_hold  <= 8'h00;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // restart on every state change, otherwise count up and saturate
            r_cnt   <= (w_next != r_state) ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
            if (w_cap) begin
                r_hold  <= w_win ? data1 : data0;
                r_last  <= w_win;
                r_grant <= w_win;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;
    logic       mclk16 = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       uart_txrdy = 1'b1;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       ack0, ack1, uart_write, busy, grant_id, err;
    logic [7:0] uart_data;
    logic       ack0_z, ack1_z, uart_write_z, busy_z, grant_id_z, err_z;
    logic [7:0] uart_data_z;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_d [4];
    logic       exp_g [4];
    logic [7:0] got_d;
    logic       got_g;

    always #5 mclk16 = ~mclk16;

    uart_tx_sched u0 (
        .mclk16(mclk16), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .uart_write(uart_write), .uart_data(uart_data), .uart_txrdy(uart_txrdy),
        .busy(busy), .grant_id(grant_id), .err(err)
    );

    uart_tx_sched #(.GAP_CYCLES(0), .ACK_TIMEOUT(32)) u1 (
        .mclk16(mclk16), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0_z),
        .req1(req1), .data1(data1), .ack1(ack1_z),
        .uart_write(uart_write_z), .uart_data(uart_data_z), .uart_txrdy(uart_txrdy),
        .busy(busy_z), .grant_id(grant_id_z), .err(err_z)
    );

    task automatic tick();
        @(posedge mclk16);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("idle", busy, 1'b0);
    endtask

    // called in the LOAD cycle: uart goes busy, then idle again
    task automatic finish_frame();
        tick();
        uart_txrdy = 1'b0;
        tick();
        uart_txrdy = 1'b1;
        wait_idle();
    endtask

    task automatic run_frame(output logic [7:0] d, output logic g);
        bit seen;
        seen = 1'b0;
        d = 'x;
        g = 'x;
        for (int i = 0; i < 200 && !seen; i++) begin
            chk("one_ack", ack0 & ack1, 1'b0);
            if (uart_write) begin
                seen = 1'b1;
                d = uart_data;
                g = grant_id;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h11; exp_d[3] = 8'h22;
        exp_g[0] = 1'b0;  exp_g[1] = 1'b1;  exp_g[2] = 1'b0;  exp_g[3] = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_write", uart_write, 1'b0);
        chk("rst_data", uart_data, 8'h00);
        chk("rst_ack0", ack0, 1'b0);
        chk("rst_ack1", ack1, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_gid", grant_id, 1'b0);

        reset = 1'b0; req0 = 1'b1; data0 = 8'hAF; #1;
        chk("a_ack0", ack0, 1'b1);
        chk("a_ack1", ack1, 1'b0);
        tick();
        req0 = 1'b0; #1;
        chk("a_write", uart_write, 1'b1);
        chk("a_data", uart_data, 8'hAF);
        chk("a_busy", busy, 1'b1);
        chk("a_gid", grant_id, 1'b0);
        chk("a_ack0_once", ack0, 1'b0);
        tick();
        chk("a_write_once", uart_write, 1'b0);
        chk("a_hold", uart_data, 8'hAF);
        uart_txrdy = 1'b0;
        tick();
        req1 = 1'b1; data1 = 8'h5C; #1;
        chk("b_ack1_wd", ack1, 1'b0);
        tick();
        chk("b_ack1_wd2", ack1, 1'b0);
        chk("b_busy", busy, 1'b1);
        uart_txrdy = 1'b1; #1;
        chk("b_ack1_rise", ack1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("b_gap_ack1", ack1, 1'b0);
            chk("b_gap_busy", busy, 1'b1);
        end
        tick();
        chk("b_ack1", ack1, 1'b1);
        chk("b_busy_idle", busy, 1'b0);
        tick();
        req1 = 1'b0; #1;
        chk("b_write", uart_write, 1'b1);
        chk("b_data", uart_data, 8'h5C);
        chk("b_gid", grant_id, 1'b1);

        tick();
        for (int k = 0; k < 31; k++) begin
            chk("c_err_early", err, 1'b0);
            tick();
        end
        req0 = 1'b1; data0 = 8'h3C; #1;
        chk("c_err", err, 1'b1);
        chk("c_busy", busy, 1'b1);
        chk("c_ack0_busy", ack0, 1'b0);
        tick();
        chk("c_err_once", err, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("c_gap_ack0", ack0, 1'b0);
            tick();
        end
        chk("c_ack0", ack0, 1'b1);
        tick();
        req0 = 1'b0; #1;
        chk("c_write", uart_write, 1'b1);
        chk("c_data", uart_data, 8'h3C);
        chk("c_gid", grant_id, 1'b0);
        finish_frame();

        reset = 1'b1;
        tick();
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22; #1;
        for (int i = 0; i < 4; i++) begin
            run_frame(got_d, got_g);
            chk("rr_data", got_d, exp_d[i]);
            chk("rr_gid", got_g, exp_g[i]);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            finish_frame();
        end

        req1 = 1'b1; data1 = 8'h88; #1;
        chk("d_ack1", ack1, 1'b1);
        tick();
        req1 = 1'b0; #1;
        chk("d_write", uart_write, 1'b1);
        tick();
        uart_txrdy = 1'b0;
        tick();
        req0 = 1'b1; data0 = 8'h77; req1 = 1'b1; #1;
        chk("d_busy", busy, 1'b1);
        chk("d_wait_ack0", ack0, 1'b0);
        chk("d_wait_ack1", ack1, 1'b0);
        reset = 1'b1;
        tick();
        chk("d_rst_busy", busy, 1'b0);
        chk("d_rst_write", uart_write, 1'b0);
        chk("d_rst_data", uart_data, 8'h00);
        chk("d_rst_gid", grant_id, 1'b0);
        chk("d_rst_ack0", ack0, 1'b0);
        chk("d_rst_ack1", ack1, 1'b0);
        chk("d_rst_err", err, 1'b0);
        reset = 1'b0; #1;
        chk("e_noack0", ack0, 1'b0);
        chk("e_noack1", ack1, 1'b0);
        tick();
        chk("e_idle", busy, 1'b0);
        chk("e_nowrite", uart_write, 1'b0);
        uart_txrdy = 1'b1; #1;
        chk("d_ack0", ack0, 1'b1);
        chk("d_ack1_lose", ack1, 1'b0);
        tick();
        req0 = 1'b0; req1 = 1'b0; #1;
        chk("d_data", uart_data, 8'h77);
        chk("d_gid", grant_id, 1'b0);
        finish_frame();

        reset = 1'b1;
        tick();
        reset = 1'b0; req0 = 1'b1; data0 = 8'h42; uart_txrdy = 1'b1; #1;
        chk("f_ack0", ack0_z, 1'b1);
        tick();
        chk("f_write", uart_write_z, 1'b1);
        chk("f_data", uart_data_z, 8'h42);
        tick();
        uart_txrdy = 1'b0; #1;
        chk("f_nack", ack0_z, 1'b0);
        tick();
        chk("f_nack2", ack0_z, 1'b0);
        uart_txrdy = 1'b1; #1;
        chk("f_rise", ack0_z, 1'b0);
        tick();
        chk("f_ack0_next", ack0_z, 1'b1);
        chk("f_busy", busy_z, 1'b0);
        tick();
        req0 = 1'b0; #1;
        chk("f_write2", uart_write_z, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 16, number of idle mclk16 cycles inserted after each frame completes (0 allowed).
REQ-002 Parameter ACK_TIMEOUT, default 32, maximum number of mclk16 cycles to wait for uart_txrdy to fall after a write.
REQ-003 Port mclk16  in  1  is the single clock, the 16x baud clock shared with uart; all logic is on its rising edge.
REQ-004 Port reset  in  1  is the reset: synchronous and active-high.
REQ-005 Port req0  in  1  is the requester 0 send request; held high until ack0.
REQ-006 Port data0  in  8  is the requester 0 byte; stable while req0 is high.
REQ-007 Port ack0  out  1  is a one-cycle pulse: the requester 0 byte has been captured.
REQ-008 Ports req1 / data1 / ack1 shall be identical to req0 / data0 / ack0 for requester 1.
REQ-009 Port uart_write  out  1  is the write strobe to uart.
REQ-010 Port uart_data  out  8  is the byte to uart.
REQ-011 Port uart_txrdy  in  1  is the uart transmitter idle flag (txrdy).
REQ-012 Port busy  out  1  is high in every state except IDLE.
REQ-013 Port grant_id  out  1  is the requester currently being served; it holds its last value when IDLE.
REQ-014 Port err  out  1  is a one-cycle pulse on ACK_TIMEOUT expiry.

Function
REQ-015 States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
REQ-016 IDLE: if any req is high and uart_txrdy=1, select a winner, capture its data into hold register, pulse its ack the same cycle, and go to LOAD.
REQ-017 Arbitration shall be round-robin using last_grant: when both requests are high, the requester != last_grant wins; a single request always wins.
REQ-018 IDLE with uart_txrdy=0 shall grant nothing and pulse no ack.
REQ-019 LOAD: uart_write=1 for exactly one cycle with uart_data=hold, then go to WAIT_BUSY.
REQ-020 uart_data shall equal hold from LOAD until the next capture; uart_write shall be 0 in every state other than LOAD.
REQ-021 WAIT_BUSY: when uart_txrdy=0, go to WAIT_DONE; a timeout counter starts at 0 on entry.
REQ-022 If the counter reaches ACK_TIMEOUT-1 with uart_txrdy still 1, pulse err and go to GAP; the byte is dropped and not retried.
REQ-023 WAIT_DONE: when uart_txrdy=1, go to GAP; there is no timeout.
REQ-024 GAP: count GAP_CYCLES cycles, then go to IDLE; if GAP_CYCLES=0, GAP lasts zero cycles (WAIT_DONE/timeout goes directly to IDLE).
REQ-025 Latency, IDLE capture to uart_write: 1 cycle; an ack always precedes the matching uart_write by 1 cycle.
REQ-026 last_grant shall update only at capture; a request arriving while busy waits, and its ack is not generated early.
REQ-027 A req dropped before ack shall be ignored without error; requests deasserted during service do not affect the frame in flight.
REQ-028 At most one ack shall be high in any cycle; never both.
REQ-029 Counters shall saturate and never wrap; the gap and timeout counters are at least clog2(max(GAP_CYCLES, ACK_TIMEOUT)+1) bits wide.

Reset
REQ-030 While reset=1 at a clock edge: state=IDLE, uart_write=0, uart_data=0, ack0=ack1=0, err=0, busy=0, grant_id=0, last_grant=1, counters=0.
REQ-031 Reset asserted in any state (including mid-frame) shall take effect on the next edge with no further uart_write; a captured-but-unsent byte is discarded.
REQ-032 After reset release, the first simultaneous request shall be granted to requester 0.

Verification
REQ-033 Reset, then req0=1, data0=8'hAF, txrdy=1 -> ack0 pulse, next cycle uart_write=1 with uart_data=8'hAF, busy=1 until the gap ends.
REQ-034 req0 and req1 high together, data 8'h11/8'h22, uart model cycling txrdy -> bytes sent in order 11, 22, 11, 22; grant_id alternates 0, 1, 0, 1.
REQ-035 uart_txrdy held 1 after write (stuck uart), ACK_TIMEOUT=32 -> err pulses exactly 32 cycles after WAIT_BUSY entry, return to IDLE after the gap, next request is served.
REQ-036 req1 raised while a frame is in WAIT_DONE -> no ack1 until after GAP_CYCLES=16 idle cycles following txrdy rise.
REQ-037 reset pulsed during WAIT_DONE -> all outputs reach their reset values next cycle, no uart_write, a pending request is re-served from requester 0 priority.
REQ-038 GAP_CYCLES=0 with back-to-back req0 -> the next ack0 falls in the cycle after txrdy rises.
